// File: rtl/prbs_gen_chk_if.sv
// Bundle of the generator, checker and status signals of prbs_gen_chk.
// The design side uses the slave modport, the driver/observer side uses master.
interface prbs_gen_chk_if #(
  parameter int NB_PAR    = 2,
  parameter int NB_ERRCNT = 16
);
  logic                 i_enable;
  logic                 i_seed_load;
  logic [NB_PAR-1:0]    o_data;
  logic                 o_valid;
  logic [NB_PAR-1:0]    i_chk_data;
  logic                 i_chk_valid;
  logic                 i_err_clr;
  logic                 o_lock;
  logic                 o_bit_err;
  logic [NB_ERRCNT-1:0] o_err_cnt;

  modport slave (
    input  i_enable, i_seed_load, i_chk_data, i_chk_valid, i_err_clr,
    output o_data, o_valid, o_lock, o_bit_err, o_err_cnt
  );

  modport master (
    output i_enable, i_seed_load, i_chk_data, i_chk_valid, i_err_clr,
    input  o_data, o_valid, o_lock, o_bit_err, o_err_cnt
  );
endinterface

// File: rtl/prbs_gen_chk.sv
// Parallel PRBS generator (NB_PAR bits/clock) and self-synchronising PRBS checker
// with lock detection and a saturating bit-error counter.
//
// state    | meaning
// S_SEARCH | loading received bits straight into the checker LFSR
// S_VERIFY | free-running prediction, counting consecutive clean words
// S_LOCKED | locked; errored bits counted, consecutive bad words drop lock
module prbs_gen_chk #(
  parameter int               ORDER      = 9,
  parameter logic [ORDER-1:0] SEED       = 9'h0AB,
  parameter int               NB_PAR     = 2,
  parameter int               NB_ERRCNT  = 16,
  parameter int               LOCK_CNT   = 16,
  parameter int               UNLOCK_ERR = 4
) (
  input logic           clk,
  input logic           rst,
  prbs_gen_chk_if.slave bus
);

  localparam int TAP = (ORDER == 7)  ? 6  :
                       (ORDER == 9)  ? 5  :
                       (ORDER == 15) ? 14 :
                       (ORDER == 23) ? 18 :
                       (ORDER == 31) ? 28 : 0;
  localparam int LOAD_WORDS = (ORDER + NB_PAR - 1) / NB_PAR;
  localparam int LW_W  = $clog2(LOAD_WORDS + 1);
  localparam int LK_W  = $clog2(LOCK_CNT + 1);
  localparam int UL_W  = $clog2(UNLOCK_ERR + 1);
  localparam int PC_W  = $clog2(NB_PAR + 1);
  localparam int SUM_W = ((NB_ERRCNT > PC_W) ? NB_ERRCNT : PC_W) + 1;

  localparam logic [LW_W-1:0]      LOAD_LAST  = LW_W'(LOAD_WORDS - 1);
  localparam logic [LK_W-1:0]      LOCK_LAST  = LK_W'(LOCK_CNT - 1);
  localparam logic [UL_W-1:0]      UNLK_LAST  = UL_W'(UNLOCK_ERR - 1);
  localparam logic [NB_ERRCNT-1:0] ERR_MAX    = '1;

  if (TAP == 0) begin : g_bad_order
    $error("prbs_gen_chk: ORDER must be one of 7, 9, 15, 23, 31");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("prbs_gen_chk: SEED must be non-zero");
  end
  if (NB_PAR < 1 || NB_PAR > 8) begin : g_bad_par
    $error("prbs_gen_chk: NB_PAR must be 1..8");
  end
  if (LOCK_CNT < 1 || UNLOCK_ERR < 1) begin : g_bad_cnt
    $error("prbs_gen_chk: LOCK_CNT and UNLOCK_ERR must be at least 1");
  end

  // ---------------------------------------------------------------- generator
  logic [ORDER-1:0]  gen_sr;
  logic [ORDER-1:0]  gen_sr_next;
  logic [NB_PAR-1:0] gen_bits;

  always_comb begin
    gen_sr_next = gen_sr;
    gen_bits    = '0;
    for (int i = 0; i < NB_PAR; i++) begin
      gen_bits[NB_PAR-1-i] = gen_sr_next[ORDER-1];
      gen_sr_next = {gen_sr_next[ORDER-2:0], gen_sr_next[ORDER-1] ^ gen_sr_next[TAP-1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_sr      <= SEED;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
    end else if (bus.i_seed_load) begin
      gen_sr      <= SEED;
      bus.o_valid <= 1'b0;
    end else if (bus.i_enable) begin
      gen_sr      <= gen_sr_next;
      bus.o_data  <= gen_bits;
      bus.o_valid <= 1'b1;
    end else begin
      bus.o_valid <= 1'b0;
    end
  end

  // ------------------------------------------------------------------ checker
  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } chk_state_t;

  chk_state_t        state, state_next;
  logic [ORDER-1:0]  chk_sr, chk_sr_next;
  logic [LW_W-1:0]   load_cnt, load_next;
  logic [LK_W-1:0]   clean_cnt, clean_next;
  logic [UL_W-1:0]   bad_cnt, bad_next;
  logic              lock_next;
  logic              bit_err_next;
  logic [NB_ERRCNT-1:0] err_cnt_next;

  logic [ORDER-1:0]  shift_sr;
  logic [ORDER-1:0]  pred_sr;
  logic [NB_PAR-1:0] pred;
  logic [NB_PAR-1:0] err_vec;
  logic [PC_W-1:0]   err_bits;
  logic [SUM_W-1:0]  err_sum;
  logic [NB_ERRCNT-1:0] err_sat;

  // The predicted bit is the feedback term: it is the next bit the remote LFSR emits.
  always_comb begin
    shift_sr = chk_sr;
    pred_sr  = chk_sr;
    pred     = '0;
    for (int i = 0; i < NB_PAR; i++) begin
      shift_sr = {shift_sr[ORDER-2:0], bus.i_chk_data[NB_PAR-1-i]};
      pred[NB_PAR-1-i] = pred_sr[ORDER-1] ^ pred_sr[TAP-1];
      pred_sr = {pred_sr[ORDER-2:0], pred[NB_PAR-1-i]};
    end
  end

  assign err_vec = pred ^ bus.i_chk_data;

  always_comb begin
    err_bits = '0;
    for (int i = 0; i < NB_PAR; i++) begin
      err_bits = err_bits + PC_W'(err_vec[i]);
    end
  end

  assign err_sum = SUM_W'(bus.o_err_cnt) + SUM_W'(err_bits);
  assign err_sat = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[NB_ERRCNT-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_SEARCH;
      chk_sr        <= '0;
      load_cnt      <= '0;
      clean_cnt     <= '0;
      bad_cnt       <= '0;
      bus.o_lock    <= 1'b0;
      bus.o_bit_err <= 1'b0;
      bus.o_err_cnt <= '0;
    end else begin
      state         <= state_next;
      chk_sr        <= chk_sr_next;
      load_cnt      <= load_next;
      clean_cnt     <= clean_next;
      bad_cnt       <= bad_next;
      bus.o_lock    <= lock_next;
      bus.o_bit_err <= bit_err_next;
      bus.o_err_cnt <= err_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    chk_sr_next  = chk_sr;
    load_next    = load_cnt;
    clean_next   = clean_cnt;
    bad_next     = bad_cnt;
    lock_next    = bus.o_lock;
    bit_err_next = 1'b0;
    err_cnt_next = bus.o_err_cnt;

    if (bus.i_chk_valid) begin
      case (state)
        S_SEARCH: begin
          chk_sr_next = shift_sr;
          if (load_cnt == LOAD_LAST) begin
            // An all-zero load would lock the LFSR up; keep loading instead.
            load_next = '0;
            if (shift_sr != '0) begin
              state_next = S_VERIFY;
              clean_next = '0;
            end
          end else begin
            load_next = load_cnt + LW_W'(1);
          end
        end
        S_VERIFY: begin
          chk_sr_next = pred_sr;
          if (err_vec != '0) begin
            state_next = S_SEARCH;
            load_next  = '0;
          end else if (clean_cnt == LOCK_LAST) begin
            state_next = S_LOCKED;
            lock_next  = 1'b1;
            bad_next   = '0;
          end else begin
            clean_next = clean_cnt + LK_W'(1);
          end
        end
        S_LOCKED: begin
          chk_sr_next = pred_sr;
          if (err_vec != '0) begin
            bit_err_next = 1'b1;
            err_cnt_next = err_sat;
            if (bad_cnt == UNLK_LAST) begin
              state_next = S_SEARCH;
              lock_next  = 1'b0;
              load_next  = '0;
            end else begin
              bad_next = bad_cnt + UL_W'(1);
            end
          end else begin
            bad_next = '0;
          end
        end
        default: begin
          state_next = S_SEARCH;
          load_next  = '0;
          lock_next  = 1'b0;
        end
      endcase
    end

    if (bus.i_err_clr) begin
      err_cnt_next = '0;
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Scoreboard bench for prbs_gen_chk: sequence-level reference model drives expectation
// queues; a negedge monitor pops and compares whatever the design presents.
module tb_prbs_gen_chk;

  localparam int               ORDER      = 9;
  localparam int               TAP        = 5;
  localparam logic [ORDER-1:0] SEED       = 9'h0AB;
  localparam int               NB_PAR     = 2;
  localparam int               NB_ERRCNT  = 4;
  localparam int               LOCK_CNT   = 16;
  localparam int               UNLOCK_ERR = 4;
  localparam int               LOAD_WORDS = (ORDER + NB_PAR - 1) / NB_PAR;
  localparam int               ERR_MAX    = (1 << NB_ERRCNT) - 1;
  localparam int               SEQ_LEN    = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs_gen_chk_if #(.NB_PAR(NB_PAR), .NB_ERRCNT(NB_ERRCNT)) bus ();

  prbs_gen_chk #(
    .ORDER(ORDER), .SEED(SEED), .NB_PAR(NB_PAR), .NB_ERRCNT(NB_ERRCNT),
    .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic                 lock;
    logic                 bit_err;
    logic [NB_ERRCNT-1:0] cnt;
  } chk_exp_t;

  int checks   = 0;
  int failures = 0;

  bit  seq[SEQ_LEN];
  int  gen_pos;
  int  chk_pos;
  logic [NB_PAR-1:0] gen_q[$];
  chk_exp_t          chk_q[$];

  // checker reference: mode 0=search 1=verify 2=locked; hist is the reference bit stream
  int m_mode, m_load, m_clean, m_bad, m_cnt;
  bit m_lock;
  bit m_hist[$];

  logic smp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected output with no expectation at %0t", name, $time);
  endtask

  function automatic logic [NB_PAR-1:0] seq_word(input int pos);
    logic [NB_PAR-1:0] w;
    for (int i = 0; i < NB_PAR; i++) w[NB_PAR-1-i] = seq[(pos + i) % SEQ_LEN];
    return w;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_load = 0; m_clean = 0; m_bad = 0; m_cnt = 0; m_lock = 0;
    m_hist.delete();
    gen_pos = 0;
    gen_q.delete();
    chk_q.delete();
  endfunction

  function automatic chk_exp_t model_chk(input logic [NB_PAR-1:0] rx, input bit vld, input bit clr);
    chk_exp_t e;
    int  nerr;
    int  n;
    bit  p;
    bit  allz;
    e.bit_err = 1'b0;
    if (vld) begin
      if (m_mode == 0) begin
        for (int i = NB_PAR - 1; i >= 0; i--) m_hist.push_back(rx[i]);
        m_load++;
        if (m_load == LOAD_WORDS) begin
          m_load = 0;
          allz = 1;
          for (int k = 1; k <= ORDER; k++) if (m_hist[m_hist.size() - k]) allz = 0;
          if (!allz) begin m_mode = 1; m_clean = 0; end
        end
      end else begin
        nerr = 0;
        for (int i = NB_PAR - 1; i >= 0; i--) begin
          n = m_hist.size();
          p = m_hist[n - ORDER] ^ m_hist[n - TAP];
          m_hist.push_back(p);
          if (p != rx[i]) nerr++;
        end
        if (m_mode == 1) begin
          if (nerr > 0) begin m_mode = 0; m_load = 0; end
          else begin
            m_clean++;
            if (m_clean == LOCK_CNT) begin m_mode = 2; m_lock = 1; m_bad = 0; end
          end
        end else begin
          if (nerr > 0) begin
            e.bit_err = 1'b1;
            m_cnt = (m_cnt + nerr > ERR_MAX) ? ERR_MAX : m_cnt + nerr;
            m_bad++;
            if (m_bad == UNLOCK_ERR) begin m_mode = 0; m_lock = 0; m_load = 0; end
          end else begin
            m_bad = 0;
          end
        end
      end
      while (m_hist.size() > 4 * ORDER) void'(m_hist.pop_front());
    end
    if (clr) m_cnt = 0;
    e.lock = m_lock;
    e.cnt  = NB_ERRCNT'(m_cnt);
    return e;
  endfunction

  task automatic cycle(input bit en, input bit ld, input logic [NB_PAR-1:0] cdata,
                       input bit cvld, input bit clr);
    bus.i_enable    = en;
    bus.i_seed_load = ld;
    bus.i_chk_data  = cdata;
    bus.i_chk_valid = cvld;
    bus.i_err_clr   = clr;
    if (ld) gen_pos = 0;
    else if (en) begin
      gen_q.push_back(seq_word(gen_pos));
      gen_pos += NB_PAR;
    end
    if (cvld || clr) chk_q.push_back(model_chk(cdata, cvld, clr));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input logic [NB_PAR-1:0] mask, input bit clr);
    cycle(($urandom_range(0, 3) != 0), 1'b0, seq_word(chk_pos) ^ mask, 1'b1, clr);
    chk_pos += NB_PAR;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_o_data",    32'(bus.o_data),    0);
    check("rst_o_valid",   32'(bus.o_valid),   0);
    check("rst_o_lock",    32'(bus.o_lock),    0);
    check("rst_o_bit_err", 32'(bus.o_bit_err), 0);
    check("rst_o_err_cnt", 32'(bus.o_err_cnt), 0);
    bus.i_enable = 0; bus.i_seed_load = 0; bus.i_chk_valid = 0; bus.i_err_clr = 0;
    bus.i_chk_data = '0;
    model_reset();
    chk_pos = $urandom_range(0, 511);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) smp <= 1'b0;
    else      smp <= bus.i_chk_valid | bus.i_err_clr;
  end

  initial begin : monitor
    logic [NB_PAR-1:0] gexp;
    chk_exp_t          cexp;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.o_valid) begin
          if (gen_q.size() == 0) fail_event("gen_extra_word");
          else begin
            gexp = gen_q.pop_front();
            check("gen_data", 32'(bus.o_data), 32'(gexp));
          end
        end
        if (smp) begin
          if (chk_q.size() == 0) fail_event("chk_extra_word");
          else begin
            cexp = chk_q.pop_front();
            check("chk_lock",    32'(bus.o_lock),    32'(cexp.lock));
            check("chk_bit_err", 32'(bus.o_bit_err), 32'(cexp.bit_err));
            check("chk_err_cnt", 32'(bus.o_err_cnt), 32'(cexp.cnt));
          end
        end else begin
          check("chk_idle_bit_err", 32'(bus.o_bit_err), 0);
        end
      end
    end
  end

  initial begin : stim
    logic [ORDER-1:0]  s;
    logic [NB_PAR-1:0] m;
    bit lock_seen;
    s = SEED;
    for (int n = 0; n < SEQ_LEN; n++)
      seq[n] = (n < ORDER) ? s[ORDER-1-n] : (seq[n-ORDER] ^ seq[n-TAP]);
    bus.i_enable = 0; bus.i_seed_load = 0; bus.i_chk_valid = 0; bus.i_err_clr = 0;
    bus.i_chk_data = '0;
    model_reset();
    #3;
    do_reset();

    // seed word then loopback-style lock after LOAD_WORDS + LOCK_CNT words
    for (int w = 1; w <= LOAD_WORDS + LOCK_CNT; w++) begin
      cycle(1'b1, 1'b0, seq_word(chk_pos), 1'b1, 1'b0);
      chk_pos += NB_PAR;
      if (w == 1) begin
        check("seed_valid", 32'(bus.o_valid), 1);
        check("seed_word0", 32'(bus.o_data), 32'h1);
      end
      if (w == LOAD_WORDS + LOCK_CNT - 1) check("lock_before_21", 32'(bus.o_lock), 0);
    end
    check("lock_at_21", 32'(bus.o_lock), 1);
    check("cnt_clean", 32'(bus.o_err_cnt), 0);

    // single-bit and double-bit errors while locked
    repeat (3) chk_word('0, 1'b0);
    chk_word(2'b01, 1'b0);
    check("single_err_pulse", 32'(bus.o_bit_err), 1);
    check("single_err_cnt",   32'(bus.o_err_cnt), 1);
    chk_word('0, 1'b0);
    check("pulse_one_cycle", 32'(bus.o_bit_err), 0);
    chk_word(2'b11, 1'b0);
    check("double_err_cnt", 32'(bus.o_err_cnt), 3);
    check("lock_kept_err",  32'(bus.o_lock), 1);

    // three bad words then clean keeps lock; four bad words drops it
    chk_word('0, 1'b0);
    repeat (3) chk_word(2'b10, 1'b0);
    chk_word('0, 1'b0);
    check("lock_after_3bad", 32'(bus.o_lock), 1);
    repeat (3) chk_word(2'b10, 1'b0);
    check("lock_before_4th", 32'(bus.o_lock), 1);
    chk_word(2'b10, 1'b0);
    check("unlock_4th", 32'(bus.o_lock), 0);
    check("cnt_after_unlock", 32'(bus.o_err_cnt), 10);

    // relock, then saturate the 4-bit counter, then clear on an errored word
    repeat (LOAD_WORDS + LOCK_CNT) chk_word('0, 1'b0);
    check("relock", 32'(bus.o_lock), 1);
    repeat (3) begin
      chk_word(2'b11, 1'b0);
      chk_word('0, 1'b0);
    end
    check("cnt_saturated", 32'(bus.o_err_cnt), 15);
    chk_word(2'b11, 1'b1);
    check("clr_with_err", 32'(bus.o_err_cnt), 0);
    check("clr_keeps_lock", 32'(bus.o_lock), 1);
    chk_word('0, 1'b0);

    // randomized traffic: enable, reload, gaps, errors, clears, bit slips
    for (int c = 0; c < 1500; c++) begin
      m = ($urandom_range(0, 19) == 0) ? NB_PAR'($urandom) : '0;
      if ($urandom_range(0, 199) == 0) chk_pos += 1;
      if ($urandom_range(0, 9) < 7) begin
        cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 63) == 0),
              seq_word(chk_pos) ^ m, 1'b1, ($urandom_range(0, 99) == 0));
        chk_pos += NB_PAR;
      end else begin
        cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 63) == 0),
              NB_PAR'($urandom), 1'b0, ($urandom_range(0, 99) == 0));
      end
    end

    // mid-operation reset while locked, then relock from search
    do_reset();
    repeat (LOAD_WORDS + LOCK_CNT + 2) chk_word('0, 1'b0);
    check("locked_before_rst", 32'(bus.o_lock), 1);
    do_reset();
    repeat (LOAD_WORDS + LOCK_CNT - 1) chk_word('0, 1'b0);
    check("no_lock_20_after_rst", 32'(bus.o_lock), 0);
    chk_word('0, 1'b0);
    check("relock_21_after_rst", 32'(bus.o_lock), 1);

    // seed reload while enabled
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, '0, 1'b0, 1'b0);
    check("reload_valid_low", 32'(bus.o_valid), 0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("reload_valid", 32'(bus.o_valid), 1);
    check("reload_word0", 32'(bus.o_data), 32'h1);

    // all-zero input must never lock
    do_reset();
    lock_seen = 0;
    for (int c = 0; c < 200; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      if (bus.o_lock) lock_seen = 1;
    end
    check("zero_never_locks", 32'(lock_seen), 0);

    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("gen_q_drained", gen_q.size(), 0);
    check("chk_q_drained", chk_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS generator plus self-synchronising PRBS checker; next generation of the single-bit PRBS9 source. Supports orders 7/9/15/23/31 and NB_PAR bits per clock, with enable and seed reload. The checker locks onto an incoming stream and counts bit errors. Used as QPSK bit source and as loopback BER monitor.

Parameters:
ORDER, 9, LFSR order; legal values 7, 9, 15, 23, 31; any other value is an elaboration error.
SEED, 9'h0AB, generator reset/reload state, ORDER bits wide; zero is an elaboration error.
NB_PAR, 2, bits generated/checked per clock, 1..8.
NB_ERRCNT, 16, error counter width.
LOCK_CNT, 16, consecutive error-free words required to declare lock.
UNLOCK_ERR, 4, consecutive errored words that drop lock.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
i_enable  in  1  generator advance enable
i_seed_load  in  1  reload generator with SEED
o_data  out  NB_PAR  generated bits, first-in-time at MSB
o_valid  out  1  o_data valid strobe
i_chk_data  in  NB_PAR  received bits, first-in-time at MSB
i_chk_valid  in  1  i_chk_data valid strobe
i_err_clr  in  1  synchronous clear of o_err_cnt
o_lock  out  1  checker locked
o_bit_err  out  1  one-cycle pulse: last checked word had at least one error while locked
o_err_cnt  out  NB_ERRCNT  saturating count of errored bits while locked

Behaviour:
- Polynomials (x^ORDER + x^TAP + 1), TAP = 6/5/14/18/28 for ORDER = 7/9/15/23/31.
- LFSR step: out = sr[ORDER-1]; fb = sr[ORDER-1]^sr[TAP-1]; sr <= {sr[ORDER-2:0], fb}. NB_PAR steps per clock (unrolled combinationally); step 0 drives o_data[NB_PAR-1].
- Reset (rst=0, async): gen sr=SEED, o_data=0, o_valid=0; checker state SEARCH, sr=0, load/lock counters=0, o_lock=0, o_bit_err=0, o_err_cnt=0.
- Generator, registered, 1-cycle latency: i_seed_load=1 -> sr<=SEED, o_valid<=0 (priority over enable). Else i_enable=1 -> o_data<=next NB_PAR bits, sr advances NB_PAR, o_valid<=1. Else o_valid<=0, o_data and sr hold.
- The first ORDER output bits after reset/reload equal SEED, MSB first.
- Checker acts only on cycles with i_chk_valid=1; all other state holds and o_bit_err=0.
- Checker FSM:
  - SEARCH: shift received bits straight into checker sr. After ceil(ORDER/NB_PAR) words, go to VERIFY, unless sr is all-zero, in which case restart the load count and stay in SEARCH.
  - VERIFY: sr advances by its own LFSR, shifting in predicted bits, never received bits. Compare predicted vs received. Any mismatch -> SEARCH. LOCK_CNT consecutive clean words -> LOCKED, o_lock<=1.
  - LOCKED: compare each word. err_bits = popcount(pred^rx), added to o_err_cnt with saturation at all-ones. o_bit_err<=1 for an errored word. UNLOCK_ERR consecutive errored words -> SEARCH, o_lock<=0. A clean word resets the consecutive-error count.
- Errors are counted only in LOCKED. Errors in SEARCH/VERIFY do not increment o_err_cnt.
- i_err_clr has priority: o_err_cnt<=0 that cycle and errors in the same word are discarded. The clear does not affect lock state.
- Checker outputs are registered, 1 cycle after the word's i_chk_valid.
- Async reset asserted mid-stream returns all state to reset values immediately. After release, the checker relocks from SEARCH.

Test Plan:
- Reset/seed: ORDER=9, NB_PAR=1, rst low then high, i_enable=1 -> o_valid=1 from the 1st cycle after enable. o_data bits 0,1,0,1,0,1,0,1,1 (=SEED). Full period 511 bits before repeat. Outputs 0 during reset.
- Loopback lock: NB_PAR=2, o_data/o_valid fed to checker continuously -> 5 load words + 16 verify words. o_lock=1 exactly one cycle after the 21st valid word. o_err_cnt stays 0.
- Single error: locked loopback, flip one bit of one word -> o_bit_err pulses once, o_err_cnt=1, o_lock stays 1. A later word with 2 flipped bits -> o_err_cnt=3.
- Unlock: locked, corrupt 4 consecutive words -> o_lock=0 after the 4th. Corrupt only 3, then a clean word -> lock retained.
- All-zero / saturation: i_chk_data=0 forever -> o_lock never asserts. NB_ERRCNT=4, sustained errors without unlock -> o_err_cnt saturates at 15. i_err_clr coincident with an errored word -> count 0.
- Mid-operation reset and reload: rst pulse while locked -> all outputs 0 immediately, relock after 21 words. i_seed_load during enable -> o_valid=0 one cycle, then the SEED sequence restarts.
